// File: rtl/load_align_unit.sv
`timescale 1ns/1ps
// load_align_unit
// Multi-cycle load path between the core and a word-wide data memory.
// Accepts one load at a time, issues one aligned read (two when the access
// straddles a word boundary), merges the returned words, extracts the
// addressed byte/half/word/dword and sign- or zero-extends it to XLEN.
// The result leaves over a valid/ready response channel.
module load_align_unit #(
    parameter int XLEN     = 32,
    parameter int AW       = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [2:0]      req_funct3,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic [AW-1:0]   mem_addr,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err
);

    // Bytes per memory word and width of the byte offset inside a word
    localparam int W    = XLEN / 8;
    localparam int OFFW = $clog2(W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_ISSUE1,
        S_WAIT1,
        S_RESP
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t            r_state;
    logic              r_req_ready;
    logic              r_mem_req;
    logic [AW-1:0]     r_mem_addr;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_data;
    logic              r_rsp_err;

    // Request fields captured at acceptance; later req_* changes are ignored
    logic [OFFW-1:0]   r_off;
    logic [2:0]        r_funct3;
    logic              r_cross;
    logic [XLEN-1:0]   r_lo;

    // ------------------------------------------------------------------
    // Request decode (only meaningful in IDLE while req_valid is high)
    // ------------------------------------------------------------------
    logic [OFFW-1:0]   w_req_off;
    logic [3:0]        w_req_nbytes;
    logic              w_req_cross;
    logic              w_req_illegal;
    logic              w_req_reject;
    logic [AW-1:0]     w_req_aligned;

    assign w_req_off     = req_addr[OFFW-1:0];
    assign w_req_nbytes  = 4'd1 << req_funct3[1:0];
    // Access straddles the word boundary when offset + size exceeds W bytes
    assign w_req_cross   = (5'(w_req_off) + 5'(w_req_nbytes)) > 5'(W);
    assign w_req_aligned = {req_addr[AW-1:OFFW], {OFFW{1'b0}}};

    // LD and LWU only exist on a 64-bit datapath; 111 is never a load
    always_comb begin
        w_req_illegal = 1'b0;
        case (req_funct3)
            3'b011:  w_req_illegal = (XLEN != 64);
            3'b110:  w_req_illegal = (XLEN != 64);
            3'b111:  w_req_illegal = 1'b1;
            default: w_req_illegal = 1'b0;
        endcase
    end

    // Requests answered with an error response and no memory traffic
    assign w_req_reject = w_req_illegal | (w_req_cross & ~SPLIT_EN);

    // ------------------------------------------------------------------
    // Data path: merge words, shift the addressed byte to bit 0, extend
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_lo_word;
    logic [XLEN-1:0]   w_hi_word;
    logic [2*XLEN-1:0] w_merged;
    logic [OFFW+2:0]   w_shamt;
    logic [XLEN-1:0]   w_raw;
    logic [3:0]        w_nbytes;
    logic [XLEN-1:0]   w_mask;
    logic              w_sign;
    logic              w_signed;
    logic [XLEN-1:0]   w_result;

    // The word arriving this cycle is used directly so the result can be
    // registered in the same cycle the last read returns
    assign w_lo_word = (r_state == S_WAIT0) ? mem_rdata : r_lo;
    assign w_hi_word = (r_state == S_WAIT1) ? mem_rdata : '0;
    assign w_merged  = {w_hi_word, w_lo_word};
    assign w_shamt   = {r_off, 3'b000};
    assign w_raw     = XLEN'(w_merged >> w_shamt);
    assign w_nbytes  = 4'd1 << r_funct3[1:0];

    // Byte lanes below the access size are kept, the rest are refilled
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_mask
            assign w_mask[8*gi +: 8] = (4'(gi) < w_nbytes) ? 8'hFF : 8'h00;
        end
    endgenerate

    // MSB of the extracted field, used as the fill bit for signed loads
    always_comb begin
        w_sign = 1'b0;
        case (r_funct3[1:0])
            2'b00:   w_sign = w_raw[7];
            2'b01:   w_sign = w_raw[15];
            2'b10:   w_sign = w_raw[31];
            default: w_sign = w_raw[XLEN-1];
        endcase
    end

    // LB/LH/LW sign-extend; U variants and LD zero-fill
    assign w_signed = ~r_funct3[2] & (r_funct3[1:0] != 2'b11);
    assign w_result = (w_raw & w_mask) | ((w_signed & w_sign) ? ~w_mask : '0);

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // Sequences accept -> read(s) -> response; outputs change with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_off       <= '0;
            r_funct3    <= '0;
            r_cross     <= 1'b0;
            r_lo        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_off       <= w_req_off;
                        r_funct3    <= req_funct3;
                        r_cross     <= w_req_cross;
                        r_req_ready <= 1'b0;
                        if (w_req_reject) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end else begin
                            r_state    <= S_ISSUE0;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_req_aligned;
                        end
                    end
                end

                S_ISSUE0: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT0;
                    end
                end

                S_WAIT0: begin
                    if (mem_rvalid) begin
                        r_lo <= mem_rdata;
                        if (r_cross) begin
                            // Next word up; the adder wraps at the top of memory
                            r_state    <= S_ISSUE1;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_mem_addr + AW'(W);
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_data  <= w_result;
                        end
                    end
                end

                S_ISSUE1: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_WAIT1;
                    end
                end

                S_WAIT1: begin
                    if (mem_rvalid) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_data  <= w_result;
                    end
                end

                S_RESP: begin
                    // req_ready rises only after the handshake, never with it
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_req   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_load_align_unit.sv
`timescale 1ns/1ps
// tb_load_align_unit
// Three instances: 32-bit with splitting (a_), 32-bit without splitting (b_),
// 64-bit with splitting (c_). Each has a one-cycle-latency memory model that
// grants every request immediately.
module tb_load_align_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        rsp_ready;
    logic        stray_rv;
    int          sel;

    int checks   = 0;
    int failures = 0;

    logic [31:0] addr_q[$];

    // ---------------- instance a: XLEN=32, SPLIT_EN=1 ----------------
    logic        a_req_valid, a_req_ready, a_mem_req, a_mem_gnt;
    logic [31:0] a_mem_addr, a_rsp_data;
    logic        a_mem_rvalid = 1'b0;
    logic [31:0] a_mem_rdata  = '0;
    logic        a_rsp_valid, a_rsp_err;

    // ---------------- instance b: XLEN=32, SPLIT_EN=0 ----------------
    logic        b_req_valid, b_req_ready, b_mem_req, b_mem_gnt;
    logic [31:0] b_mem_addr, b_rsp_data;
    logic        b_mem_rvalid = 1'b0;
    logic [31:0] b_mem_rdata  = '0;
    logic        b_rsp_valid, b_rsp_err;

    // ---------------- instance c: XLEN=64, SPLIT_EN=1 ----------------
    logic        c_req_valid, c_req_ready, c_mem_req, c_mem_gnt;
    logic [31:0] c_mem_addr;
    logic [63:0] c_rsp_data;
    logic        c_mem_rvalid = 1'b0;
    logic [63:0] c_mem_rdata  = '0;
    logic        c_rsp_valid, c_rsp_err;

    assign a_req_valid = req_valid && (sel == 0);
    assign b_req_valid = req_valid && (sel == 1);
    assign c_req_valid = req_valid && (sel == 2);
    assign a_mem_gnt   = a_mem_req;
    assign b_mem_gnt   = b_mem_req;
    assign c_mem_gnt   = c_mem_req;

    load_align_unit #(.XLEN(32), .AW(32), .SPLIT_EN(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3),
        .mem_req(a_mem_req), .mem_gnt(a_mem_gnt), .mem_addr(a_mem_addr),
        .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(a_rsp_data), .rsp_err(a_rsp_err)
    );

    load_align_unit #(.XLEN(32), .AW(32), .SPLIT_EN(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3),
        .mem_req(b_mem_req), .mem_gnt(b_mem_gnt), .mem_addr(b_mem_addr),
        .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
    );

    load_align_unit #(.XLEN(64), .AW(32), .SPLIT_EN(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .req_valid(c_req_valid), .req_ready(c_req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3),
        .mem_req(c_mem_req), .mem_gnt(c_mem_gnt), .mem_addr(c_mem_addr),
        .mem_rvalid(c_mem_rvalid), .mem_rdata(c_mem_rdata),
        .rsp_valid(c_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(c_rsp_data), .rsp_err(c_rsp_err)
    );

    function automatic logic [31:0] mem32(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem32 = 32'h8899AABB;
            32'h0000_0104: mem32 = 32'h11223344;
            32'hFFFF_FFFC: mem32 = 32'hCAFEF00D;
            32'h0000_0000: mem32 = 32'h01020304;
            default:       mem32 = 32'hDEADBEEF;
        endcase
    endfunction

    function automatic logic [63:0] mem64(input logic [31:0] a);
        case (a)
            32'h0000_0108: mem64 = 64'h0011223344556677;
            32'h0000_0110: mem64 = 64'h8899AABBCCDDEEFF;
            32'h0000_0200: mem64 = 64'h0000000080000000;
            default:       mem64 = 64'hDEADBEEFDEADBEEF;
        endcase
    endfunction

    // Memory models: read data one cycle after grant, plus optional stray pulse
    always @(posedge clk) begin
        a_mem_rvalid <= (a_mem_req & a_mem_gnt) | stray_rv;
        a_mem_rdata  <= mem32(a_mem_addr);
        b_mem_rvalid <= (b_mem_req & b_mem_gnt) | stray_rv;
        b_mem_rdata  <= mem32(b_mem_addr);
        c_mem_rvalid <= (c_mem_req & c_mem_gnt) | stray_rv;
        c_mem_rdata  <= mem64(c_mem_addr);
        if (a_mem_req && a_mem_gnt) addr_q.push_back(a_mem_addr);
        if (b_mem_req && b_mem_gnt) addr_q.push_back(b_mem_addr);
        if (c_mem_req && c_mem_gnt) addr_q.push_back(c_mem_addr);
    end

    // Response of the currently selected instance
    logic        s_req_ready, s_rsp_valid, s_rsp_err;
    logic [63:0] s_rsp_data;
    always_comb begin
        s_req_ready = a_req_ready;
        s_rsp_valid = a_rsp_valid;
        s_rsp_err   = a_rsp_err;
        s_rsp_data  = {32'h0, a_rsp_data};
        if (sel == 1) begin
            s_req_ready = b_req_ready;
            s_rsp_valid = b_rsp_valid;
            s_rsp_err   = b_rsp_err;
            s_rsp_data  = {32'h0, b_rsp_data};
        end else if (sel == 2) begin
            s_req_ready = c_req_ready;
            s_rsp_valid = c_rsp_valid;
            s_rsp_err   = c_rsp_err;
            s_rsp_data  = c_rsp_data;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    typedef struct {
        int          sel;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [63:0] data;
        logic        err;
        int          cyc;
        int          nreq;
        logic [31:0] a0;
        logic [31:0] a1;
        int          hold;
    } vec_t;

    function automatic vec_t mk(input int s, input logic [31:0] a, input logic [2:0] f,
                                input logic [63:0] d, input logic e, input int cy,
                                input int n, input logic [31:0] a0, input logic [31:0] a1,
                                input int h);
        vec_t v;
        v.sel = s; v.addr = a; v.f3 = f; v.data = d; v.err = e;
        v.cyc = cy; v.nreq = n; v.a0 = a0; v.a1 = a1; v.hold = h;
        return v;
    endfunction

    // One full transaction: accept, wait response, optional stall, handshake
    task automatic run_vec(input vec_t v, input int idx);
        int    cyc;
        bit    done;
        string t;
        t = $sformatf("v%0d", idx);
        addr_q.delete();
        @(negedge clk);
        sel        = v.sel;
        req_addr   = v.addr;
        req_funct3 = v.f3;
        req_valid  = 1'b1;
        #1;
        chk({t, " req_ready_idle"}, 64'(s_req_ready), 64'd1);
        @(posedge clk);
        #1;
        // Scramble request inputs after acceptance; the unit must ignore them
        req_valid  = 1'b0;
        req_addr   = ~v.addr;
        req_funct3 = 3'b111;
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            if (s_rsp_valid) done = 1'b1;
            else cyc++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual=no_rsp required=rsp_valid", t);
        end else begin
            chk({t, " latency"},  64'(cyc),         64'(v.cyc));
            chk({t, " data"},     s_rsp_data,       v.data);
            chk({t, " err"},      64'(s_rsp_err),   64'(v.err));
            chk({t, " req_ready_busy"}, 64'(s_req_ready), 64'd0);
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                chk({t, $sformatf(" hold%0d valid", h)}, 64'(s_rsp_valid), 64'd1);
                chk({t, $sformatf(" hold%0d data", h)},  s_rsp_data,       v.data);
                chk({t, $sformatf(" hold%0d ready", h)}, 64'(s_req_ready), 64'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            chk({t, " rsp_valid_after"}, 64'(s_rsp_valid), 64'd0);
            chk({t, " req_ready_after"}, 64'(s_req_ready), 64'd1);
        end
        chk({t, " nreq"}, 64'(addr_q.size()), 64'(v.nreq));
        if (v.nreq >= 1 && addr_q.size() >= 1) chk({t, " addr0"}, 64'(addr_q[0]), 64'(v.a0));
        if (v.nreq >= 2 && addr_q.size() >= 2) chk({t, " addr1"}, 64'(addr_q[1]), 64'(v.a1));
    endtask

    vec_t vecs[18];

    initial begin
        bit seen;
        vecs[0]  = mk(0, 32'h103, 3'b000, 64'h00000000FFFFFF88, 0, 3, 1, 32'h100, 32'h0, 0);
        vecs[1]  = mk(0, 32'h103, 3'b100, 64'h0000000000000088, 0, 3, 1, 32'h100, 32'h0, 0);
        vecs[2]  = mk(0, 32'h102, 3'b001, 64'h00000000FFFF8899, 0, 3, 1, 32'h100, 32'h0, 0);
        vecs[3]  = mk(0, 32'h100, 3'b101, 64'h000000000000AABB, 0, 3, 1, 32'h100, 32'h0, 0);
        vecs[4]  = mk(0, 32'h100, 3'b010, 64'h000000008899AABB, 0, 3, 1, 32'h100, 32'h0, 4);
        vecs[5]  = mk(0, 32'h103, 3'b010, 64'h0000000022334488, 0, 5, 2, 32'h100, 32'h104, 0);
        vecs[6]  = mk(0, 32'h103, 3'b001, 64'h0000000000004488, 0, 5, 2, 32'h100, 32'h104, 0);
        vecs[7]  = mk(0, 32'h101, 3'b001, 64'h00000000FFFF99AA, 0, 3, 1, 32'h100, 32'h0, 0);
        vecs[8]  = mk(0, 32'h100, 3'b011, 64'h0, 1, 1, 0, 32'h0, 32'h0, 0);
        vecs[9]  = mk(0, 32'h100, 3'b111, 64'h0, 1, 1, 0, 32'h0, 32'h0, 0);
        vecs[10] = mk(0, 32'hFFFFFFFE, 3'b010, 64'h000000000304CAFE, 0, 5, 2, 32'hFFFFFFFC, 32'h0, 0);
        vecs[11] = mk(1, 32'h103, 3'b001, 64'h0, 1, 1, 0, 32'h0, 32'h0, 0);
        vecs[12] = mk(1, 32'h100, 3'b010, 64'h000000008899AABB, 0, 3, 1, 32'h100, 32'h0, 0);
        vecs[13] = mk(1, 32'h101, 3'b101, 64'h00000000000099AA, 0, 3, 1, 32'h100, 32'h0, 0);
        vecs[14] = mk(2, 32'h10C, 3'b011, 64'hCCDDEEFF00112233, 0, 5, 2, 32'h108, 32'h110, 0);
        vecs[15] = mk(2, 32'h200, 3'b110, 64'h0000000080000000, 0, 3, 1, 32'h200, 32'h0, 0);
        vecs[16] = mk(2, 32'h200, 3'b010, 64'hFFFFFFFF80000000, 0, 3, 1, 32'h200, 32'h0, 0);
        vecs[17] = mk(2, 32'h117, 3'b000, 64'hFFFFFFFFFFFFFF88, 0, 3, 1, 32'h110, 32'h0, 0);

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        rsp_ready  = 1'b0;
        stray_rv   = 1'b0;
        sel        = 0;

        #12;
        chk("reset a req_ready", 64'(a_req_ready), 64'd1);
        chk("reset a mem_req",   64'(a_mem_req),   64'd0);
        chk("reset a mem_addr",  64'(a_mem_addr),  64'd0);
        chk("reset a rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("reset a rsp_err",   64'(a_rsp_err),   64'd0);
        chk("reset c rsp_data",  c_rsp_data,       64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Reset while waiting for the second word of a split load
        addr_q.delete();
        @(negedge clk);
        sel = 0; req_addr = 32'h103; req_funct3 = 3'b010; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (a_mem_req && a_mem_addr == 32'h104) seen = 1'b1;
        end
        chk("rst_mid issue1 reached", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid req_ready", 64'(a_req_ready), 64'd1);
        chk("rst_mid mem_req",   64'(a_mem_req),   64'd0);
        chk("rst_mid mem_addr",  64'(a_mem_addr),  64'd0);
        chk("rst_mid rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst_mid rsp_err",   64'(a_rsp_err),   64'd0);
        chk("rst_mid rsp_data",  64'(a_rsp_data),  64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        stray_rv = 1'b1;
        @(negedge clk);
        stray_rv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("late_rvalid%0d rsp_valid", k), 64'(a_rsp_valid), 64'd0);
            chk($sformatf("late_rvalid%0d mem_req", k),   64'(a_mem_req),   64'd0);
            chk($sformatf("late_rvalid%0d req_ready", k), 64'(a_req_ready), 64'd1);
        end

        // Normal operation resumes after the abort
        run_vec(vecs[5], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
